ov5640_dvp_capture: RTL and testbench

- Camera-side producer for the video pixel FIFO. Samples the OV5640 DVP bus (vsync, href, 8-bit data) on the pixel clock, pairs bytes into RGB565 words and writes them into the FIFO that the HDMI/VGA timing interface drains.
- Aligns capture to frame boundaries, crops each frame to the active window, drops pixels on FIFO full and reports frame and error status.

---
 rtl/ov5640_dvp_capture.sv | 137 +++++++++++++
 tb/tb_ov5640_dvp_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: registers the camera bus, pairs bytes into RGB565
// words, crops to the active window and writes them into the pixel FIFO.
module ov5640_dvp_capture #(
    parameter int H_ACTIVE          = 640,
    parameter int V_ACTIVE          = 480,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_full,
    output logic [15:0] fifo_data_out,
    output logic        fifo_write_en,
    output logic        frame_active,
    output logic        frame_done,
    output logic        overflow,
    output logic [9:0]  line_count
);

    localparam int PW = $clog2(H_ACTIVE + 1);

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

    state_t          state;
    logic            vs_r, href_r;
    logic [7:0]      data_r;
    logic            vs_act, vs_d, href_d;
    logic            vs_rise, vs_fall, href_fall;
    logic            phase;       // 0: expecting high byte, 1: expecting low byte
    logic [7:0]      hi_byte;
    logic [PW-1:0]   pix_cnt;     // saturates at H_ACTIVE
    logic [15:0]     word;
    logic            word_vld;    // word formed last edge and allowed to be written
    logic            in_window;

    assign vs_act    = VSYNC_ACTIVE_HIGH ? vs_r : ~vs_r;
    assign vs_rise   = vs_act & ~vs_d;
    assign vs_fall   = ~vs_act & vs_d;
    assign href_fall = ~href_r & href_d;
    assign in_window = (pix_cnt < PW'(H_ACTIVE)) && (line_count < 10'(V_ACTIVE));

    // Register the raw camera bus once before any use
    always_ff @(posedge clock) begin
        if (reset) begin
            vs_r   <= 1'b0;
            href_r <= 1'b0;
            data_r <= 8'h00;
        end else begin
            vs_r   <= cam_vsync;
            href_r <= cam_href;
            data_r <= cam_data;
        end
    end

    // Frame FSM, byte pairing, window gating and the registered write stage
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            vs_d          <= 1'b0;
            href_d        <= 1'b0;
            phase         <= 1'b0;
            hi_byte       <= 8'h00;
            pix_cnt       <= '0;
            word          <= 16'h0000;
            word_vld      <= 1'b0;
            fifo_data_out <= 16'h0000;
            fifo_write_en <= 1'b0;
            frame_active  <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            line_count    <= '0;
        end else begin
            vs_d       <= vs_act;
            href_d     <= href_r;
            frame_done <= 1'b0;
            word_vld   <= 1'b0;
            // A word formed just before the frame ends is not written
            fifo_write_en <= word_vld && (state == CAPTURE) && !vs_rise;
            if (word_vld)
                fifo_data_out <= word;

            case (state)
                IDLE: begin
                    if (enable)
                        state <= SYNC;
                end
                SYNC: begin
                    // Only a full active->inactive transition starts a frame
                    if (vs_fall) begin
                        state        <= CAPTURE;
                        frame_active <= 1'b1;
                        line_count   <= '0;
                        pix_cnt      <= '0;
                        phase        <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        // Line end coinciding with frame end is counted first
                        if (href_fall && line_count < 10'(V_ACTIVE))
                            line_count <= line_count + 10'd1;
                        frame_done   <= 1'b1;
                        frame_active <= 1'b0;
                        phase        <= 1'b0;
                        state        <= enable ? SYNC : IDLE;
                    end else if (href_r) begin
                        if (!phase) begin
                            hi_byte <= data_r;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            word  <= {hi_byte, data_r};
                            if (pix_cnt < PW'(H_ACTIVE))
                                pix_cnt <= pix_cnt + PW'(1);
                            if (in_window) begin
                                if (fifo_full)
                                    overflow <= 1'b1;
                                else
                                    word_vld <= 1'b1;
                            end
                        end
                    end else if (href_fall) begin
                        phase   <= 1'b0;
                        pix_cnt <= '0;
                        if (line_count < 10'(V_ACTIVE))
                            line_count <= line_count + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Scoreboard bench for ov5640_dvp_capture: the driver computes the expected
// FIFO words (value and arrival cycle) from the capture rules, a monitor pops
// and compares them on every write strobe.
module tb_ov5640_dvp_capture;

    localparam int H = 16;
    localparam int V = 6;

    logic        clock = 1'b0;
    logic        reset, enable, cam_vsync, cam_href, fifo_full;
    logic [7:0]  cam_data;
    logic [15:0] fifo_data_out;
    logic        fifo_write_en, frame_active, frame_done, overflow;
    logic [9:0]  line_count;

    ov5640_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_ACTIVE_HIGH(1'b1)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .fifo_full(fifo_full), .fifo_data_out(fifo_data_out),
        .fifo_write_en(fifo_write_en), .frame_active(frame_active),
        .frame_done(frame_done), .overflow(overflow), .line_count(line_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] w;
        int          t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0, fails = 0;
    int   fd_cnt = 0;
    bit   cap = 1'b0;     // model: a frame is being captured
    int   lmod = 0;       // model: lines completed in current frame
    exp_t e;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected word and its cycle
    always @(negedge clock) begin
        if (frame_done) fd_cnt++;
        if (fifo_write_en) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got %h at cyc %0d, none expected", fifo_data_out, cyc);
            end else begin
                e = q.pop_front();
                if (e.w !== fifo_data_out || e.t != cyc) begin
                    fails++;
                    $display("FAIL write got %h at cyc %0d, exp %h at cyc %0d", fifo_data_out, cyc, e.w, e.t);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    // One href line of np byte pairs (+ optional odd byte); pixels flo..fhi see
    // fifo_full at their word-formation cycle. abort_at asserts reset there.
    task automatic drive_line(input int np, input bit odd, input int flo, input int fhi,
                              input bit rnd, input int abort_at);
        logic [7:0] hi, lo;
        bit f, fprev;
        exp_t x;
        fprev = 1'b0;
        for (int p = 0; p < np; p++) begin
            f  = (p >= flo && p <= fhi);
            hi = rnd ? 8'($urandom) : 8'hF8;
            lo = rnd ? 8'($urandom) : 8'h00;
            @(negedge clock);
            if (p == abort_at) begin
                reset = 1'b1;
                cam_href = 1'b0;
                while (q.size() > 0 && q[q.size()-1].t > cyc) q.pop_back();
                cap = 1'b0;
                return;
            end
            cam_href = 1'b1; cam_data = hi; fifo_full = fprev;
            @(negedge clock);
            cam_data = lo; fifo_full = f;
            if (cap && lmod < V && p < H && !f) begin
                x.w = {hi, lo};
                x.t = cyc + 3;
                q.push_back(x);
            end
            fprev = f;
        end
        if (odd) begin
            @(negedge clock);
            cam_href = 1'b1; cam_data = 8'($urandom); fifo_full = fprev;
        end
        @(negedge clock);
        cam_href = 1'b0; fifo_full = fprev;
        repeat (4) begin
            @(negedge clock);
            fifo_full = 1'b0;
        end
        if (cap && lmod < V) lmod++;
    endtask

    task automatic vs_pulse();
        @(negedge clock); cam_vsync = 1'b1;
        repeat (3) @(negedge clock);
        cam_vsync = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int f0;
        reset = 1'b1; enable = 1'b0; cam_vsync = 1'b0;
        cam_href = 1'b0; cam_data = 8'h00; fifo_full = 1'b0;
        // Reset while the camera streams
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            cam_href = 1'b1; cam_data = 8'($urandom);
        end
        chk("rst_data", 32'(fifo_data_out), 32'h0);
        chk("rst_wen", 32'(fifo_write_en), 32'h0);
        chk("rst_active", 32'(frame_active), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_lines", 32'(line_count), 32'h0);
        @(negedge clock); reset = 1'b0; cam_href = 1'b0;

        // IDLE, then enable mid-stream without a vsync pulse: no writes
        drive_line(5, 1'b0, -1, -1, 1'b1, -1);
        enable = 1'b1;
        drive_line(6, 1'b0, -1, -1, 1'b1, -1);
        chk("sync_wait_inactive", 32'(frame_active), 32'h0);

        // Frame 1
        vs_pulse(); cap = 1'b1; lmod = 0;
        chk("frame_start", 32'(frame_active), 32'h1);
        drive_line(H, 1'b0, -1, -1, 1'b0, -1);
        chk("lines_after_1", 32'(line_count), 32'd1);
        drive_line(H + 3, 1'b1, -1, -1, 1'b1, -1);
        chk("lines_after_long", 32'(line_count), 32'd2);
        drive_line(H, 1'b0, -1, -1, 1'b1, -1);
        chk("ovf_before_full", 32'(overflow), 32'h0);
        drive_line(H, 1'b0, 10, 12, 1'b1, -1);
        chk("ovf_set", 32'(overflow), 32'h1);
        enable = 1'b0;   // no effect until frame end
        drive_line(0, 1'b1, -1, -1, 1'b1, -1);
        chk("empty_line_counts", 32'(line_count), 32'd5);
        drive_line($urandom_range(H + 4, H - 4), 1'b0, -1, -1, 1'b1, -1);
        drive_line(H, 1'b0, -1, -1, 1'b1, -1);
        drive_line(H, 1'b0, -1, -1, 1'b1, -1);
        chk("lines_saturate", 32'(line_count), 32'(V));
        chk("active_after_en_drop", 32'(frame_active), 32'h1);

        // Frame end with enable low -> IDLE
        f0 = fd_cnt;
        @(negedge clock); cam_vsync = 1'b1;
        repeat (4) @(negedge clock);
        cap = 1'b0;
        chk("frame_done_once", 32'(fd_cnt - f0), 32'd1);
        chk("frame_inactive", 32'(frame_active), 32'h0);
        chk("lines_at_end", 32'(line_count), 32'(V));
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Enable during vertical blank: nothing until vsync falls
        drive_line(5, 1'b0, -1, -1, 1'b1, -1);
        enable = 1'b1;
        drive_line(5, 1'b0, -1, -1, 1'b1, -1);
        chk("blank_no_capture", 32'(frame_active), 32'h0);
        @(negedge clock); cam_vsync = 1'b0;
        repeat (3) @(negedge clock);
        cap = 1'b1; lmod = 0;
        chk("frame2_start", 32'(frame_active), 32'h1);
        drive_line(H, 1'b0, -1, -1, 1'b1, -1);
        chk("frame2_lines", 32'(line_count), 32'd1);

        // Reset in the middle of a line
        drive_line(H, 1'b0, -1, -1, 1'b1, 5);
        @(negedge clock);
        chk("rst_mid_wen", 32'(fifo_write_en), 32'h0);
        chk("rst_mid_ovf", 32'(overflow), 32'h0);
        chk("rst_mid_active", 32'(frame_active), 32'h0);
        chk("rst_mid_lines", 32'(line_count), 32'h0);
        reset = 1'b0;
        drive_line(4, 1'b0, -1, -1, 1'b1, -1);
        repeat (4) @(negedge clock);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
